// File: rtl/enc_window_buffer_pkg.sv
// Shared encoder constants, word type and window-buffer state encoding.
package enc_window_buffer_pkg;

    localparam int ENC_SYM_NUM = 4;
    localparam int EGF_ORDER   = 8;
    localparam int ENC_WORD_W  = ENC_SYM_NUM * EGF_ORDER;

    typedef logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] enc_word_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } win_state_e;

    localparam enc_word_t ZERO_WORD = {ENC_WORD_W{1'b0}};

endpackage

// File: rtl/enc_window_ctrl.sv
// Window control: FSM, fill counter, flush injection counter and both handshakes.
module enc_window_ctrl
    import enc_window_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       in_ready,
    output logic                       accept,
    output logic                       inject,
    output logic                       sof_clear,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] out_fill,
    output logic                       busy
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH);
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [CW-1:0] INJ_LAST  = CW'(DEPTH - 2);

    win_state_e    state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] inj_q, inj_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          shift_s;

    // Handshake and shift qualification
    always_comb begin
        in_ready  = (state_q != ST_FLUSH) && (!valid_q || out_ready);
        accept    = in_valid && in_ready;
        inject    = (state_q == ST_FLUSH) && (!valid_q || out_ready);
        sof_clear = accept && in_sof;
        shift_s   = accept || inject;
    end

    // Next-state, fill count, injection count and window-valid
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        inj_d   = inj_q;
        valid_d = valid_q;

        if (accept) begin
            if (in_sof) begin
                fill_d = FW'(1);
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            fill_d = fill_q;
        end

        // Fill is evaluated after the same-cycle word so flush+word enters FLUSH
        case (state_q)
            ST_FILL, ST_RUN: begin
                if (flush && (fill_d != {FW{1'b0}})) begin
                    state_d = ST_FLUSH;
                    inj_d   = {CW{1'b0}};
                end else if (fill_d == FILL_FULL) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (inject) begin
                    if (inj_q == INJ_LAST) begin
                        fill_d  = {FW{1'b0}};
                        inj_d   = {CW{1'b0}};
                        state_d = ST_FILL;
                    end else begin
                        inj_d = inj_q + CW'(1);
                    end
                end else begin
                    inj_d = inj_q;
                end
            end
            default: begin
                state_d = ST_FILL;
                fill_d  = {FW{1'b0}};
                inj_d   = {CW{1'b0}};
            end
        endcase

        if (shift_s) begin
            valid_d = inject || (fill_d == FILL_FULL);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d == ST_FLUSH);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= {FW{1'b0}};
            inj_q   <= {CW{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            inj_q   <= inj_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_fill  = fill_q;
    assign busy      = busy_q;

endmodule

// File: rtl/enc_window_buffer.sv
// Sliding window of the last DEPTH encoder words with sof realignment and zero flush.
module enc_window_buffer
    import enc_window_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sof,
    input  enc_word_t                         in_data,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DEPTH*ENC_WORD_W-1:0]       out_data,
    output logic [$clog2(DEPTH+1)-1:0]        out_fill,
    output logic                              busy
);

    enc_word_t [DEPTH-1:0] slot_q, slot_d;
    logic                  accept_s;
    logic                  inject_s;
    logic                  sof_clear_s;

    enc_window_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .flush     (flush),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .accept    (accept_s),
        .inject    (inject_s),
        .sof_clear (sof_clear_s),
        .out_valid (out_valid),
        .out_fill  (out_fill),
        .busy      (busy)
    );

    // Shift mux: slot 0 takes the new or zero word, older slots age or clear on sof
    always_comb begin
        slot_d = slot_q;
        if (accept_s || inject_s) begin
            if (inject_s) begin
                slot_d[0] = ZERO_WORD;
            end else begin
                slot_d[0] = in_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (sof_clear_s) begin
                    slot_d[k] = ZERO_WORD;
                end else begin
                    slot_d[k] = slot_q[k-1];
                end
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Slot array
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= {DEPTH{ZERO_WORD}};
        end else begin
            slot_q <= slot_d;
        end
    end

    assign out_data = slot_q;

endmodule

// File: tb/tb_enc_window_buffer.sv
// Directed and random bench for enc_window_buffer (DEPTH=3) against a queue-style window model.
module tb_enc_window_buffer;
    import enc_window_buffer_pkg::*;

    localparam int D     = 3;
    localparam int W     = ENC_WORD_W;
    localparam int OUT_W = D * W;
    localparam int FW    = $clog2(D + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sof = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [FW-1:0]    out_fill;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: window contents (index 0 newest), fill, valid, injections left
    logic [W-1:0] m_win [D];
    int           m_fill;
    bit           m_valid;
    int           m_left;

    always #5 clk = ~clk;

    enc_window_buffer #(.DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_fill  (out_fill),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_window();
        logic [OUT_W-1:0] v;
        v = '0;
        for (int k = 0; k < D; k++) v[k*W +: W] = m_win[k];
        return v;
    endfunction

    task automatic model_shift_in(input logic [W-1:0] w);
        for (int k = D - 1; k > 0; k--) m_win[k] = m_win[k-1];
        m_win[0] = w;
    endtask

    // One clock: drive, check in_ready, advance model across the edge, check outputs
    task automatic step(input bit v, input bit sof, input logic [W-1:0] d, input bit fl, input bit ordy);
        bit rdy, acc, inj, was;
        in_valid = v; in_sof = sof; in_data = d; flush = fl; out_ready = ordy;
        #1;
        rdy = (m_left == 0) && (!m_valid || ordy);
        chk("in_ready", OUT_W'(in_ready), OUT_W'(rdy));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int k = 0; k < D; k++) m_win[k] = '0;
            m_fill = 0; m_valid = 1'b0; m_left = 0;
        end else begin
            acc = v && rdy;
            was = (m_left > 0);
            inj = was && (!m_valid || ordy);
            if (acc) begin
                if (sof) begin
                    for (int k = 0; k < D; k++) m_win[k] = '0;
                    m_win[0] = d;
                    m_fill = 1;
                end else begin
                    model_shift_in(d);
                    if (m_fill < D) m_fill = m_fill + 1;
                end
            end
            if (inj) begin
                model_shift_in('0);
                m_left = m_left - 1;
                if (m_left == 0) m_fill = 0;
            end
            if (acc || inj) m_valid = inj || (m_fill == D);
            else if (ordy) m_valid = 1'b0;
            if (fl && !was && m_fill >= 1) m_left = D - 1;
        end
        chk("out_valid", OUT_W'(out_valid), OUT_W'(m_valid));
        chk("out_fill",  OUT_W'(out_fill),  OUT_W'(m_fill));
        chk("busy",      OUT_W'(busy),      OUT_W'(m_left > 0));
        chk("out_data",  out_data,          model_window());
    endtask

    initial begin
        logic [W-1:0] w [12];
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        for (int k = 0; k < D; k++) m_win[k] = '0;
        m_fill = 0; m_valid = 1'b0; m_left = 0;

        // Reset with garbage on inputs, then release
        step(1'b1, 1'b1, w[0], 1'b1, 1'b1);
        step(1'b1, 1'b0, w[1], 1'b0, 1'b0);
        chk("reset_data", out_data, {OUT_W{1'b0}});
        rst_n = 1'b1;

        // Streaming with a frame start, one window per cycle once full
        step(1'b1, 1'b1, w[0], 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, w[i], 1'b0, 1'b1);

        // Backpressure holds the window and blocks input
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, w[8], 1'b0, 1'b0);
        step(1'b1, 1'b0, w[8], 1'b0, 1'b1);

        // Frame W0..W4 then flush: two zero injections
        step(1'b1, 1'b1, w[0], 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) step(1'b1, 1'b0, w[i], 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("flush_win1", out_data, {w[3], w[4], {W{1'b0}}});
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("flush_win2", out_data, {w[4], {W{1'b0}}, {W{1'b0}}});
        chk("flush_end_fill", OUT_W'(out_fill), OUT_W'(0));
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Mid-stream sof realigns the window
        step(1'b1, 1'b1, w[5], 1'b0, 1'b1);
        step(1'b1, 1'b0, w[6], 1'b0, 1'b1);
        step(1'b1, 1'b0, w[7], 1'b0, 1'b1);
        step(1'b1, 1'b1, w[9], 1'b0, 1'b1);
        chk("sof_realign", out_data, {{W{1'b0}}, {W{1'b0}}, w[9]});
        step(1'b1, 1'b0, w[10], 1'b0, 1'b1);
        step(1'b1, 1'b0, w[11], 1'b0, 1'b1);

        // Flush together with an accepted word
        step(1'b1, 1'b0, w[2], 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, ($urandom % 10) == 0, $urandom,
                 ($urandom % 16) == 0, ($urandom % 3) != 0);
        end

        // Reset in the middle of a flush with a valid window
        step(1'b1, 1'b1, w[0], 1'b0, 1'b1);
        step(1'b1, 1'b0, w[1], 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("pre_reset_busy", OUT_W'(busy), OUT_W'(1));
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("reset_valid", OUT_W'(out_valid), OUT_W'(0));
        chk("reset_busy", OUT_W'(busy), OUT_W'(0));
        chk("reset_slots", out_data, {OUT_W{1'b0}});
        rst_n = 1'b1;
        step(1'b1, 1'b1, w[3], 1'b0, 1'b0);
        step(1'b1, 1'b0, w[4], 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/enc_window_buffer.md
# enc_window_buffer

Parametrised sliding-window buffer between the encoder datapath and the downstream word-framing logic. Generalises the two-word stall buffer to DEPTH words, with valid/ready handshaking on both sides, frame-start realignment and an end-of-frame zero-flush. The output presents the most recent DEPTH encoder words as one flat symbol vector.

## Interface
- DEPTH, 2: number of encoder words held in the window; legal values ≥ 2.
- ENC_SYM_NUM, EGF_ORDER: shared package constants, not overridden per instance.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data/in_sof are valid.
- in_ready  out  1  the buffer accepts a word this cycle.
- in_sof  in  1  the accepted word is the first word of a frame.
- in_data  in  ENC_SYM_NUM×EGF_ORDER  encoder word, as a packed symbol array.
- flush  in  1  single-cycle request to drain the current frame.
- out_valid  out  1  out_data holds a full window not yet consumed.
- out_ready  in  1  downstream consumes the window.
- out_data  out  DEPTH·ENC_SYM_NUM×EGF_ORDER  window. Slot 0 (low ENC_SYM_NUM symbols) is the newest word; slot DEPTH-1 is the oldest.
- out_fill  out  $clog2(DEPTH+1)  number of real (non-reset, non-flush) words in the window, saturating at DEPTH.
- busy  out  1  FLUSH state active.

## Operation
- Shift event: the buffer shifts when (in_valid && in_ready) or when it injects a flush word. On a shift, each slot k moves to slot k+1, slot DEPTH-1 is discarded, and slot 0 loads the new word.
- in_ready = (state != FLUSH) && (!out_valid || out_ready).
- in_sof on an accepted word: clear slots 1..DEPTH-1 to zero, load the word into slot 0, and set out_fill to 1. No partial window from a previous frame is ever emitted mixed with the new frame.
- State machine:
  - FILL: out_fill < DEPTH. Go to RUN when out_fill reaches DEPTH.
  - RUN: steady state.
  - FLUSH: entered from FILL/RUN on flush when out_fill ≥ 1. In this state the block injects DEPTH-1 all-zero words, one per cycle, each gated by (!out_valid || out_ready). After the last injection it clears out_fill to 0 and returns to FILL.
- flush with out_fill == 0 is ignored. flush while in FLUSH is ignored.
- flush in the same cycle as an accepted input word: the word is accepted first, then FLUSH is entered.
- out_valid:
  - Set on any shift that leaves out_fill == DEPTH, and on every flush injection.
  - Cleared on out_ready when no shift occurs in the same cycle.
  - A shift together with out_ready keeps it at 1 (back-to-back windows).
- out_fill: increments on a real accepted word (saturates at DEPTH), is unchanged by flush injections, and follows the sof and flush-end rules above.

## Timing
- Reset values: all slots 0, out_valid 0, out_fill 0, busy 0, state FILL. in_ready is 1 in the cycle after reset release.
- Latency: an accepted word appears in slot 0 on the next cycle. The window is first valid DEPTH accepted words after sof.
- Throughput: one word per cycle while out_ready is held high.
- out_ready low with out_valid high: in_ready = 0 and the window is held stable.
- rst_n low in mid-frame or mid-flush returns everything to the reset values on the next edge. Pending flush injections are dropped.

## Structure
- The shared encoder package holds ENC_SYM_NUM, EGF_ORDER, the encoder word typedef (ENC_SYM_NUM×EGF_ORDER) and the state enum {FILL, RUN, FLUSH}.
- Natural sub-module: enc_window_ctrl, containing the FSM, out_fill counter, flush injection counter and handshake logic. The top module holds the slot array and the shift mux.

## Test plan
- DEPTH=2; reset, then sof+A, B with out_ready=1 -> out_valid first at the cycle after B, out_data = {A,B} (B in slot 0), out_fill = 2.
- DEPTH=4; stream W0..W7 (sof on W0) with out_ready=1 -> windows {W0..W3} through {W4..W7} on consecutive cycles, one new window per cycle.
- DEPTH=4; window valid, out_ready=0 for 3 cycles -> in_ready=0 and out_data stable. When out_ready rises, the next word is accepted in the same cycle.
- DEPTH=3; W0..W4 then flush -> busy for 2 injections, windows {W3,W4,0} then {W4,0,0}, then out_fill = 0 and state FILL.
- sof on W9 while the window holds W5..W7 (DEPTH=3) -> slots {0,0,W9}, out_fill = 1, out_valid stays 0 until W11.
- rst_n low during flush with out_valid=1 -> next cycle out_valid = 0, busy = 0, slots zero, in_ready = 1.
